// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: next-PC select encoding,
// 2-bit saturating counter states and the counter update function.
package bp_pkg;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4    = 2'b00,
    PC_SEL_PRED     = 2'b01,
    PC_SEL_EX_TGT   = 2'b10,
    PC_SEL_EX_PLUS4 = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } cnt2_e;

  localparam cnt2_e CNT_RESET = WEAK_NT;
  localparam cnt2_e CNT_ALLOC = WEAK_T;

  function automatic cnt2_e sat_cnt_next(input cnt2_e cnt, input logic taken);
    cnt2_e nxt;
    nxt = cnt;
    if (taken && (cnt != STRONG_T)) begin
      nxt = cnt2_e'(cnt + 2'd1);
    end else if (!taken && (cnt != STRONG_NT)) begin
      nxt = cnt2_e'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/module_bp_table.sv
// Direct-mapped BTB storage: two combinational read ports (fetch and EX) and
// one write port. Reset clears valid bits and parks counters at weak-not-taken.
module module_bp_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_a,
  output logic                       rd_valid_a,
  output logic [XLEN-$clog2(ENTRIES)-3:0] rd_tag_a,
  output logic [XLEN-1:0]            rd_target_a,
  output cnt2_e                      rd_cnt_a,
  input  logic [$clog2(ENTRIES)-1:0] rd_idx_b,
  output logic                       rd_valid_b,
  output logic [XLEN-$clog2(ENTRIES)-3:0] rd_tag_b,
  output logic [XLEN-1:0]            rd_target_b,
  output cnt2_e                      rd_cnt_b,
  input  logic                       wr_en,
  input  logic [$clog2(ENTRIES)-1:0] wr_idx,
  input  logic [XLEN-$clog2(ENTRIES)-3:0] wr_tag,
  input  logic [XLEN-1:0]            wr_target,
  input  cnt2_e                      wr_cnt
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = XLEN - INDEX_W - 2;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  cnt2_e             cnt_q    [ENTRIES];

  // Tags and targets need no reset: they are qualified by the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RESET;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
      cnt_q[wr_idx]    <= wr_cnt;
    end
  end

  assign rd_valid_a  = valid_q[rd_idx_a];
  assign rd_tag_a    = tag_q[rd_idx_a];
  assign rd_target_a = target_q[rd_idx_a];
  assign rd_cnt_a    = cnt_q[rd_idx_a];

  assign rd_valid_b  = valid_q[rd_idx_b];
  assign rd_tag_b    = tag_q[rd_idx_b];
  assign rd_target_b = target_q[rd_idx_b];
  assign rd_cnt_b    = cnt_q[rd_idx_b];

endmodule

// File: rtl/module_branch_predictor.sv
// BTB + 2-bit counter branch predictor driving the next-PC 4:1 select.
// Optional perf counters are built when BP_PERF_CNT_EN is defined.
module module_branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic [XLEN-1:0] pc_if_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic            ex_is_branch_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            ex_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            mispredict_o,
  output logic [1:0]      pc_sel_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispred_cnt_o
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = XLEN - INDEX_W - 2;

  logic [INDEX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]   if_tag, ex_tag;
  logic               if_valid, ex_valid;
  logic [TAG_W-1:0]   if_rd_tag, ex_rd_tag;
  logic [XLEN-1:0]    if_target, ex_old_target;
  cnt2_e              if_cnt, ex_cnt;

  logic               if_hit, ex_hit;
  logic               upd, mismatch, mispredict;
  logic               wr_en;
  logic [XLEN-1:0]    wr_target;
  cnt2_e              wr_cnt;
  pc_sel_e            pc_sel;

  assign if_idx = pc_if_i[INDEX_W+1:2];
  assign if_tag = pc_if_i[XLEN-1:INDEX_W+2];
  assign ex_idx = ex_pc_i[INDEX_W+1:2];
  assign ex_tag = ex_pc_i[XLEN-1:INDEX_W+2];

  module_bp_table #(
    .ENTRIES (ENTRIES),
    .XLEN    (XLEN)
  ) u_table (
    .clk         (clk),
    .rst         (rst),
    .rd_idx_a    (if_idx),
    .rd_valid_a  (if_valid),
    .rd_tag_a    (if_rd_tag),
    .rd_target_a (if_target),
    .rd_cnt_a    (if_cnt),
    .rd_idx_b    (ex_idx),
    .rd_valid_b  (ex_valid),
    .rd_tag_b    (ex_rd_tag),
    .rd_target_b (ex_old_target),
    .rd_cnt_b    (ex_cnt),
    .wr_en       (wr_en),
    .wr_idx      (ex_idx),
    .wr_tag      (ex_tag),
    .wr_target   (wr_target),
    .wr_cnt      (wr_cnt)
  );

  // Fetch-side lookup; reset forces a sequential (pc+4) prediction.
  assign if_hit        = ~rst & if_valid & (if_rd_tag == if_tag);
  assign pred_taken_o  = if_hit & if_cnt[1];
  assign pred_target_o = if_hit ? if_target : (pc_if_i + XLEN'(4));

  assign ex_hit   = ex_valid & (ex_rd_tag == ex_tag);
  assign upd      = ex_valid_i & ex_is_branch_i & ~stall_i & ~rst;
  assign mismatch = (ex_taken_i != ex_pred_taken_i) |
                    (ex_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i));
  assign mispredict   = upd & mismatch;
  assign mispredict_o = mispredict;

  // A not-taken miss allocates nothing; a not-taken hit keeps its old target.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = ex_target_i;
    wr_cnt    = CNT_ALLOC;
    if (upd) begin
      if (ex_hit) begin
        wr_en     = 1'b1;
        wr_cnt    = sat_cnt_next(ex_cnt, ex_taken_i);
        wr_target = ex_taken_i ? ex_target_i : ex_old_target;
      end else if (ex_taken_i) begin
        wr_en = 1'b1;
      end
    end
  end

  always_comb begin
    pc_sel = PC_SEL_PLUS4;
    if (mispredict) begin
      pc_sel = ex_taken_i ? PC_SEL_EX_TGT : PC_SEL_EX_PLUS4;
    end else if (pred_taken_o) begin
      pc_sel = PC_SEL_PRED;
    end
  end

  assign pc_sel_o = pc_sel;

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd)        branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o  = branch_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_module_branch_predictor.sv
// Directed self-checking bench for module_branch_predictor (ENTRIES=16, XLEN=32).
module tb_module_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc_if;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        mispredict;
  logic [1:0]  pc_sel;
  logic [31:0] branch_cnt, mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  module_branch_predictor #(
    .ENTRIES (16),
    .XLEN    (32)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .stall_i          (stall),
    .pc_if_i          (pc_if),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_is_branch_i   (ex_is_branch),
    .ex_pc_i          (ex_pc),
    .ex_taken_i       (ex_taken),
    .ex_target_i      (ex_target),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .mispredict_o     (mispredict),
    .pc_sel_o         (pc_sel),
    .branch_cnt_o     (branch_cnt),
    .mispred_cnt_o    (mispred_cnt)
  );

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid       = v;
    ex_is_branch   = v;
    ex_pc          = pc;
    ex_taken       = tk;
    ex_target      = tgt;
    ex_pred_taken  = ptk;
    ex_pred_target = ptgt;
  endtask

  // Resolve a correctly-predicted branch for one cycle, then retire it.
  task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    set_ex(1'b1, pc, tk, tgt, tk, tgt);
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0;
    pc_if = 32'h100;
    set_ex(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    step();
    step();
    #1;
    checks++;
    if (mispredict !== 1'b0) begin
      errors++; $display("FAIL rst_mispredict got %b exp 0", mispredict);
    end
    checks++;
    if (pc_sel !== 2'b00) begin
      errors++; $display("FAIL rst_pc_sel got %b exp 00", pc_sel);
    end
    rst = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL reset_pred_taken got %b exp 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h104) begin
      errors++; $display("FAIL reset_pred_target got %h exp 00000104", pred_target);
    end
    checks++;
    if (pc_sel !== 2'b00) begin
      errors++; $display("FAIL reset_pc_sel got %b exp 00", pc_sel);
    end
  endtask

  task automatic test_alloc();
    pc_if = 32'h100;
    set_ex(1'b1, 32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    #1;
    checks++;
    if (mispredict !== 1'b1) begin
      errors++; $display("FAIL alloc_mispredict got %b exp 1", mispredict);
    end
    checks++;
    if (pc_sel !== 2'b10) begin
      errors++; $display("FAIL alloc_pc_sel got %b exp 10", pc_sel);
    end
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL alloc_rdw_old got %b exp 0", pred_taken);
    end
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL alloc_pred_taken got %b exp 1", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h40) begin
      errors++; $display("FAIL alloc_pred_target got %h exp 00000040", pred_target);
    end
    checks++;
    if (pc_sel !== 2'b01) begin
      errors++; $display("FAIL alloc_pc_sel_pred got %b exp 01", pc_sel);
    end
  endtask

  task automatic test_counter_walk();
    pc_if = 32'h100;
    resolve(32'h100, 1'b1, 32'h40);               // 10 -> 11
    resolve(32'h100, 1'b1, 32'h40);               // 11 stays 11
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL walk_sat_hi got %b exp 1", pred_taken);
    end
    // Predicted taken but resolves not-taken: redirect to EX pc+4.
    set_ex(1'b1, 32'h100, 1'b0, 32'h40, 1'b1, 32'h40);
    #1;
    checks++;
    if (mispredict !== 1'b1 || pc_sel !== 2'b11) begin
      errors++; $display("FAIL walk_nt_redirect got %b/%b exp 1/11", mispredict, pc_sel);
    end
    step();                                        // 11 -> 10
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL walk_nt1 got %b exp 1", pred_taken);
    end
    resolve(32'h100, 1'b0, 32'h40);               // 10 -> 01
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL walk_nt2 got %b exp 0", pred_taken);
    end
    checks++;
    if (pred_target !== 32'h40) begin
      errors++; $display("FAIL walk_nt_keeps_target got %h exp 00000040", pred_target);
    end
    resolve(32'h100, 1'b0, 32'h40);               // 01 -> 00
    resolve(32'h100, 1'b0, 32'h40);               // 00 stays 00
    resolve(32'h100, 1'b1, 32'h40);               // 00 -> 01
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL walk_sat_lo got %b exp 0", pred_taken);
    end
    resolve(32'h100, 1'b1, 32'h40);               // 01 -> 10
    checks++;
    if (pred_taken !== 1'b1) begin
      errors++; $display("FAIL walk_back_up got %b exp 1", pred_taken);
    end
  endtask

  task automatic test_alias();
    resolve(32'h140, 1'b1, 32'h200);              // replaces index 0
    pc_if = 32'h100;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
      errors++; $display("FAIL alias_evicted got %b/%h exp 0/00000104", pred_taken, pred_target);
    end
    pc_if = 32'h140;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      errors++; $display("FAIL alias_new got %b/%h exp 1/00000200", pred_taken, pred_target);
    end
    resolve(32'h180, 1'b0, 32'h300);              // not-taken miss: no write
    pc_if = 32'h140;
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h200) begin
      errors++; $display("FAIL alias_nt_miss got %b/%h exp 1/00000200", pred_taken, pred_target);
    end
    pc_if = 32'h180;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h184) begin
      errors++; $display("FAIL alias_nt_noalloc got %b/%h exp 0/00000184", pred_taken, pred_target);
    end
  endtask

  task automatic test_wrong_target();
    resolve(32'h104, 1'b1, 32'h40);
    pc_if = 32'h104;
    set_ex(1'b1, 32'h104, 1'b1, 32'h80, 1'b1, 32'h40);
    #1;
    checks++;
    if (mispredict !== 1'b1 || pc_sel !== 2'b10) begin
      errors++; $display("FAIL wrong_tgt_redirect got %b/%b exp 1/10", mispredict, pc_sel);
    end
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
      errors++; $display("FAIL wrong_tgt_update got %b/%h exp 1/00000080", pred_taken, pred_target);
    end
  endtask

  task automatic test_stall();
    pc_if = 32'h108;
    stall = 1'b1;
    set_ex(1'b1, 32'h108, 1'b1, 32'h300, 1'b0, 32'h10c);
    #1;
    checks++;
    if (mispredict !== 1'b0 || pc_sel !== 2'b00) begin
      errors++; $display("FAIL stall_redirect got %b/%b exp 0/00", mispredict, pc_sel);
    end
    step();
    step();
    step();
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h10c) begin
      errors++; $display("FAIL stall_no_update got %b/%h exp 0/0000010c", pred_taken, pred_target);
    end
    stall = 1'b0;
    #1;
    checks++;
    if (mispredict !== 1'b1 || pc_sel !== 2'b10) begin
      errors++; $display("FAIL unstall_redirect got %b/%b exp 1/10", mispredict, pc_sel);
    end
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      errors++; $display("FAIL unstall_update got %b/%h exp 1/00000300", pred_taken, pred_target);
    end
    // A single allocation leaves 10, so one not-taken drops the prediction.
    resolve(32'h108, 1'b0, 32'h300);
    checks++;
    if (pred_taken !== 1'b0) begin
      errors++; $display("FAIL stall_single_update got %b exp 0", pred_taken);
    end
  endtask

  task automatic test_reset_with_update();
    pc_if = 32'h10c;
    rst = 1'b1;
    set_ex(1'b1, 32'h10c, 1'b1, 32'h400, 1'b0, 32'h110);
    step();
    rst = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h110) begin
      errors++; $display("FAIL rst_upd_discard got %b/%h exp 0/00000110", pred_taken, pred_target);
    end
    pc_if = 32'h140;
    #1;
    checks++;
    if (pred_taken !== 1'b0 || pred_target !== 32'h144) begin
      errors++; $display("FAIL rst_clears_table got %b/%h exp 0/00000144", pred_taken, pred_target);
    end
    checks++;
    if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++; $display("FAIL rst_perf_cnt got %h/%h exp 0/0", branch_cnt, mispred_cnt);
    end
    // One mispredicting branch after reset.
    set_ex(1'b1, 32'h10c, 1'b1, 32'h400, 1'b0, 32'h110);
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
`ifdef BP_PERF_CNT_EN
    checks++;
    if (branch_cnt !== 32'h1 || mispred_cnt !== 32'h1) begin
      errors++; $display("FAIL perf_cnt_count got %h/%h exp 1/1", branch_cnt, mispred_cnt);
    end
`else
    checks++;
    if (branch_cnt !== 32'h0 || mispred_cnt !== 32'h0) begin
      errors++; $display("FAIL perf_cnt_tied got %h/%h exp 0/0", branch_cnt, mispred_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter_walk();
    test_alias();
    test_wrong_target();
    test_stall();
    test_reset_with_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
